// File: rtl/usb_tx_serializer.sv
// rtl/usb_tx_serializer.sv - USB-style TX serializer: SYNC, NRZI, EOP; bit stuffing when BIT_STUFF_EN is defined
module usb_tx_serializer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int PACKET_WIDTH = 88
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    load,
    input  logic [PACKET_WIDTH-1:0] shift_data,
    input  logic [6:0]              pkt_bits,
    output logic                    d_plus,
    output logic                    d_minus,
    output logic                    busy,
    output logic                    done
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [6:0]     MAX_BITS = 7'(PACKET_WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    state_t                  state;
    logic [CW-1:0]           clk_cnt;
    logic [6:0]              bit_cnt;
    logic [6:0]              nbits;
    logic [PACKET_WIDTH-1:0] shreg;
    logic                    line_j;

    logic bit_end;
    logic sync_left;
    logic data_left;
    logic tx_bit;
    logic line_nx;
    logic stuff_now;

    assign bit_end   = (clk_cnt == LAST_CLK);
    // In SYNC, bit_cnt is the index of the sync bit on the line; in DATA/STUFF it counts data bits sent.
    assign sync_left = (state == SYNC) && (bit_cnt != 7'd7);
    assign data_left = (state == SYNC) || (bit_cnt < nbits);
    // Next logical bit: remaining SYNC bits are 0 except the last; otherwise the packet MSB.
    assign tx_bit    = sync_left ? (bit_cnt == 7'd6) : shreg[PACKET_WIDTH-1];
    // NRZI: a 0 toggles the line, a 1 holds it.
    assign line_nx   = tx_bit ? line_j : ~line_j;

`ifdef BIT_STUFF_EN
    logic [2:0] ones_cnt;
    assign stuff_now = (ones_cnt == 3'd6);
`else
    assign stuff_now = 1'b0;
`endif

    // Transmit FSM: paces each line bit over CLKS_PER_BIT clocks and drives registered line/status outputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            nbits   <= '0;
            shreg   <= '0;
            line_j  <= 1'b1;
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef BIT_STUFF_EN
            ones_cnt <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                clk_cnt <= '0;
                if (load && (pkt_bits != 7'd0)) begin
                    state   <= SYNC;
                    busy    <= 1'b1;
                    nbits   <= (pkt_bits > MAX_BITS) ? MAX_BITS : pkt_bits;
                    shreg   <= shift_data;
                    bit_cnt <= '0;
                    // First SYNC bit is a 0: the idle J turns into K.
                    line_j  <= 1'b0;
                    d_plus  <= 1'b0;
                    d_minus <= 1'b1;
`ifdef BIT_STUFF_EN
                    ones_cnt <= '0;
`endif
                end
            end else if (!bit_end) begin
                clk_cnt <= clk_cnt + CW'(1);
            end else begin
                clk_cnt <= '0;
                case (state)
                    SYNC, DATA, STUFF: begin
                        if (stuff_now) begin
                            state   <= STUFF;
                            line_j  <= ~line_j;
                            d_plus  <= ~line_j;
                            d_minus <= line_j;
`ifdef BIT_STUFF_EN
                            ones_cnt <= '0;
`endif
                        end else if (sync_left || data_left) begin
                            line_j  <= line_nx;
                            d_plus  <= line_nx;
                            d_minus <= ~line_nx;
`ifdef BIT_STUFF_EN
                            ones_cnt <= tx_bit ? (ones_cnt + 3'd1) : 3'd0;
`endif
                            if (sync_left) begin
                                bit_cnt <= bit_cnt + 7'd1;
                            end else begin
                                state   <= DATA;
                                shreg   <= shreg << 1;
                                bit_cnt <= (state == SYNC) ? 7'd1 : (bit_cnt + 7'd1);
                            end
                        end else begin
                            state   <= EOP_SE0;
                            bit_cnt <= '0;
                            d_plus  <= 1'b0;
                            d_minus <= 1'b0;
                        end
                    end
                    EOP_SE0: begin
                        if (bit_cnt == 7'd0) begin
                            bit_cnt <= 7'd1;
                        end else begin
                            state   <= EOP_J;
                            line_j  <= 1'b1;
                            d_plus  <= 1'b1;
                            d_minus <= 1'b0;
                        end
                    end
                    EOP_J: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// tb/tb_usb_tx_serializer.sv - self-checking bench for usb_tx_serializer
module tb_usb_tx_serializer;

    localparam int CPB = 8;
`ifdef BIT_STUFF_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic        load = 1'b0;
    logic [87:0] shift_data = '0;
    logic [6:0]  pkt_bits = '0;
    logic        d_plus;
    logic        d_minus;
    logic        busy;
    logic        done;

    int          n_pass = 0;
    int          n_total = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  cmp_exp;
    bit          chk_en = 1'b0;
    int          busy_run = 0;
    int          last_busy_len = 0;

    always #5 clk = ~clk;

    usb_tx_serializer #(.CLKS_PER_BIT(CPB), .PACKET_WIDTH(88)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (load),
        .shift_data (shift_data),
        .pkt_bits   (pkt_bits),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %s expected %s", name, act, exp);
    endtask

    // Line symbols per bit time: J, K, or 0 for SE0.
    function automatic string model_line(input logic [87:0] d, input int n_raw);
        bit    bits[$];
        bit    tx[$];
        int    n;
        int    ones;
        bit    lvl_j;
        string s;
        n = (n_raw > 88) ? 88 : n_raw;
        for (int i = 0; i < 7; i++) bits.push_back(1'b0);
        bits.push_back(1'b1);
        for (int i = 0; i < n; i++) bits.push_back(d[87-i]);
        ones = 0;
        foreach (bits[i]) begin
            tx.push_back(bits[i]);
            ones = bits[i] ? ones + 1 : 0;
            if (STUFF_ON && ones == 6) begin
                tx.push_back(1'b0);
                ones = 0;
            end
        end
        s = "";
        lvl_j = 1'b1;
        foreach (tx[i]) begin
            if (!tx[i]) lvl_j = !lvl_j;
            s = {s, lvl_j ? "J" : "K"};
        end
        s = {s, "00J"};
        return s;
    endfunction

    task automatic push_packet(input logic [87:0] d, input int n);
        string      s;
        byte        c;
        logic [1:0] sym;
        s = model_line(d, n);
        for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            sym = (c == "J") ? 2'b10 : ((c == "K") ? 2'b01 : 2'b00);
            repeat (CPB) exp_q.push_back({sym, 1'b1, 1'b0});
        end
        exp_q.push_back(4'b1001);
    endtask

    // Called at posedge+1; load is sampled on the next rising edge.
    task automatic issue_load(input logic [87:0] d, input logic [6:0] n, input bit accept);
        shift_data = d;
        pkt_bits   = n;
        load       = 1'b1;
        @(posedge clk);
        if (accept) push_packet(d, int'(n));
        #1 load = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_idle_timeout", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Per-cycle comparison of line and status against the model's expected stream.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() > 0) cmp_exp = exp_q.pop_front();
            else cmp_exp = 4'b1000;
            check("line_cycle", {d_plus, d_minus, busy, done}, cmp_exp);
        end
    end

    // Length of the most recent busy window.
    always @(negedge clk) begin
        if (busy) busy_run <= busy_run + 1;
        else if (busy_run != 0) begin
            last_busy_len <= busy_run;
            busy_run      <= 0;
        end
    end

    initial begin
        int k;
        #2 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_state", {d_plus, d_minus, busy, done}, 4'b1000);
        n_rst  = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check_str("model_a5", model_line({8'hA5, 80'd0}, 8), "KJKJKJKKKJJKJJKK00J");
        check_str("model_six_ones", model_line({6'b111111, 82'd0}, 6),
                  STUFF_ON ? "KJKJKJKKKKKKKJJ00J" : "KJKJKJKKKKKKKK00J");

        // pkt_bits=0 in IDLE is ignored.
        issue_load({8'hFF, 80'd0}, 7'd0, 1'b0);
        repeat (20) @(posedge clk);
        #1;

        // A5 packet; input changes and a load while busy must not disturb it.
        issue_load({8'hA5, 80'd0}, 7'd8, 1'b1);
        shift_data = '0;
        pkt_bits   = 7'd3;
        repeat (30) @(posedge clk);
        #1;
        issue_load(88'd0, 7'd8, 1'b0);
        wait_idle(400);
        check("busy_len_a5", last_busy_len, 152);

        // Six ones: SYNC 1 plus five data ones trigger a stuff bit.
        issue_load({6'b111111, 82'd0}, 7'd6, 1'b1);
        wait_idle(400);
        check("busy_len_six_ones", last_busy_len, STUFF_ON ? 144 : 136);

        // Reset in the middle of DATA.
        issue_load({8'hA5, 80'd0}, 7'd8, 1'b1);
        repeat (8 * CPB + 20) @(posedge clk);
        #1;
        chk_en = 1'b0;
        exp_q.delete();
        n_rst = 1'b0;
        #1 check("reset_mid_packet", {d_plus, d_minus, busy, done}, 4'b1000);
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        chk_en = 1'b1;
        repeat (200) @(posedge clk);
        #1;

        // FFFF packet, then a load on the done edge (ignored) held into the done cycle (accepted).
        issue_load({16'hFFFF, 72'd0}, 7'd16, 1'b1);
        k = 0;
        while (exp_q.size() != 2 && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        check("wait_last_busy_timeout", exp_q.size(), 2);
        shift_data = 88'h5555555555555555555555;
        pkt_bits   = 7'd100;
        load       = 1'b1;
        @(posedge clk);
        #1 check("done_pulse", done, 1);
        @(posedge clk);
        push_packet(88'h5555555555555555555555, 100);
        #1 load = 1'b0;
        check("busy_len_ffff", last_busy_len, STUFF_ON ? 232 : 216);
        check("busy_back_to_back", busy, 1);
        wait_idle(2000);
        check("busy_len_clamped", last_busy_len, 792);

        repeat (5) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
